// File: rtl/lcd_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : lcd_update_queue
// Description : Queues retired-instruction records and paces them to an LCD
//               controller with a holdoff between update strobes.
//               Optional macro LCD_QUEUE_OVERWRITE_EN: a push into a full FIFO
//               replaces the newest entry instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_update_queue #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 40000
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    input  logic        system_on,
    input  logic        instr_done,
    input  logic [2:0]  instr_opcode,
    input  logic [3:0]  instr_reg,
    input  logic [15:0] instr_value,
    input  logic        lcd_ready,
    output logic        display_enable,
    output logic [2:0]  opcode_last,
    output logic [3:0]  reg_number,
    output logic [15:0] reg_value,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [3:0]  count,
    output logic        overflow
);

    localparam int             PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [3:0]     DEPTH_C   = 4'(DEPTH);
    localparam logic [15:0]    HOLD_LAST = 16'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       hold_cnt;
    logic [15:0]       hold_cnt_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [22:0]       mem [DEPTH];
    logic              push_req;
    logic              pop;
    logic              do_push;
    logic              do_overwrite;
    logic              push_blocked;

    assign fifo_full    = (count == DEPTH_C);
    assign fifo_empty   = (count == 4'd0);
    assign push_req     = instr_done & system_on;
    // A concurrent pop frees a slot, so a full FIFO can still accept the push.
    assign do_push      = push_req & (~fifo_full | pop);
    assign push_blocked = push_req & fifo_full & ~pop;
`ifdef LCD_QUEUE_OVERWRITE_EN
    assign do_overwrite = push_blocked;
`else
    assign do_overwrite = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && lcd_ready) begin
                    state_next = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE: begin
                state_next    = HOLD;
                hold_cnt_next = 16'd0;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (lcd_ready) begin
                        state_next = IDLE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!system_on) begin
            state_next    = IDLE;
            hold_cnt_next = 16'd0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            hold_cnt       <= 16'd0;
            display_enable <= 1'b0;
        end else begin
            state          <= state_next;
            hold_cnt       <= hold_cnt_next;
            display_enable <= (state_next == ISSUE);
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else if (!system_on) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + {3'b000, do_push} - {3'b000, pop};
            if (push_blocked) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge clk_50MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= {instr_opcode, instr_reg, instr_value};
        end else if (do_overwrite) begin
            mem[wr_ptr - PTR_ONE] <= {instr_opcode, instr_reg, instr_value};
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            opcode_last <= 3'd0;
            reg_number  <= 4'd0;
            reg_value   <= 16'd0;
        end else if (pop) begin
            {opcode_last, reg_number, reg_value} <= mem[rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: doc/lcd_update_queue.md
LCD_UPDATE_QUEUE -- requirements
Module: lcd_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..8).
REQ-002 SHALL have parameter HOLDOFF, default 40000, meaning minimum clk cycles between successive display_enable pulses (1..65535).
REQ-003 SHALL have one clock, clk_50MHz, and an asynchronous active-low reset, reset_n; all state changes on the rising edge of clk_50MHz.
REQ-004 SHALL have port clk_50MHz  in  1  system clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port system_on  in  1  1 = CPU powered; 0 = flush and halt.
REQ-007 SHALL have port instr_done  in  1  one-cycle retire pulse from the CPU.
REQ-008 SHALL have port instr_opcode  in  3  opcode of the retired instruction.
REQ-009 SHALL have port instr_reg  in  4  destination/source register number.
REQ-010 SHALL have port instr_value  in  16  signed register value.
REQ-011 SHALL have port lcd_ready  in  1  1 = LCD controller idle and able to accept an update.
REQ-012 SHALL have port display_enable  out  1  one-cycle update strobe to the LCD controller.
REQ-013 SHALL have ports opcode_last/reg_number/reg_value  out  3/4/16  registered payload, stable from the strobe until the next strobe.
REQ-014 SHALL have ports fifo_full, fifo_empty  out  1 each  FIFO status; count  out  4  occupancy; overflow  out  1  sticky drop flag.

Function
REQ-015 SHALL push {instr_opcode, instr_reg, instr_value} on every edge where instr_done=1 and system_on=1, if not full or a pop occurs on the same edge.
REQ-016 SHALL, when full with no pop and without LCD_QUEUE_OVERWRITE_EN, drop the push, leave the FIFO unchanged, and set overflow.
REQ-017 SHALL use a three-state FSM: IDLE, ISSUE, HOLD.
REQ-018 SHALL, in IDLE with fifo non-empty, lcd_ready=1 and system_on=1, load the head entry into the payload registers, pop it, and assert display_enable on the next edge, entering ISSUE.
REQ-019 SHALL hold display_enable high for exactly one cycle (ISSUE), then enter HOLD with holdoff counter cleared.
REQ-020 SHALL, in HOLD, increment the counter each cycle and return to IDLE only when the counter has reached HOLDOFF-1 and lcd_ready=1; otherwise saturate the counter and wait.
REQ-021 SHALL give a latency of two edges from a push into an empty FIFO (FSM in IDLE, lcd_ready=1) to display_enable high.
REQ-022 SHALL preserve FIFO order; the pointers SHALL wrap modulo DEPTH; count SHALL equal pushes minus pops and never exceed DEPTH.
REQ-023 SHALL, with system_on=0, empty the FIFO, force the FSM to IDLE, drive display_enable low, and ignore instr_done; the payload registers SHALL hold their values.
REQ-024 SHALL clear overflow only on reset.

Reset
REQ-025 SHALL, on reset_n=0 (including mid-ISSUE or mid-HOLD), immediately set FSM=IDLE, counter=0, pointers=0, count=0, fifo_empty=1, fifo_full=0, overflow=0, display_enable=0, opcode_last=0, reg_number=0, reg_value=0.

Configuration
REQ-026 SHALL honour macro LCD_QUEUE_OVERWRITE_EN: when defined, a push to a full FIFO with no concurrent pop SHALL overwrite the newest (tail) entry and set overflow; when undefined, REQ-016 applies.

Verification
REQ-027 SHALL cover: single push {op=3'b001, reg=4'd5, value=16'h0007}, lcd_ready=1 -> display_enable high exactly 2 edges later with payload 001/0101/0007, count back to 0.
REQ-028 SHALL cover: 3 pushes on consecutive cycles, lcd_ready=1, HOLDOFF=10 -> three strobes in push order, spaced 12 cycles apart (1 ISSUE + 10 HOLD + 1 IDLE).
REQ-029 SHALL cover: DEPTH=4, lcd_ready=0, 5 pushes values 1..5 -> fifo_full=1, overflow=1; after lcd_ready=1, strobes 1,2,3,4 (undefined macro) or 1,2,3,5 (macro defined).
REQ-030 SHALL cover: lcd_ready held 0 during HOLD for 100 cycles beyond HOLDOFF -> no strobe until 1 cycle after lcd_ready rises.
REQ-031 SHALL cover: system_on dropped with 2 entries queued -> count=0 next edge, no strobe; instr_done during system_on=0 is ignored; payload unchanged.
REQ-032 SHALL cover: reset_n pulsed low during HOLD -> all outputs at REQ-025 values asynchronously; a subsequent push strobes after the 2-edge latency.
